reg_access_ctrl: RTL and testbench
==================================

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 Parameter WR_CMD, default 8'hAA, command byte that opens a write frame.
REQ-002 Parameter RD_CMD, default 8'hBB, command byte that opens a read frame.
REQ-003 Parameter RD_TIMEOUT, default 15, max cycles to wait for Rd_D_Vid after RdEn.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 RX_P_DATA  input  8  received UART byte.
REQ-007 RX_D_VLD  input  1  one-cycle strobe, RX_P_DATA valid.
REQ-008 WrEn  output  1  register-file write strobe.
REQ-009 RdEn  output  1  register-file read strobe.
REQ-010 Address  output  4  register-file address.
REQ-011 WrData  output  8  register-file write data.
REQ-012 RdData  input  8  register-file read data.
REQ-013 Rd_D_Vid  input  1  register-file read-data valid.
REQ-014 TX_P_DATA  output  8  byte to UART transmitter.
REQ-015 TX_D_VLD  output  1  one-cycle strobe, TX_P_DATA valid.
REQ-016 TX_BUSY  input  1  transmitter busy; no TX_D_VLD while high.
REQ-017 FRAME_ERR  output  1  one-cycle pulse on any aborted frame.

Function
REQ-018 FSM states SHALL be IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
REQ-019 IDLE: RX_D_VLD with WR_CMD -> WR_ADDR; with RD_CMD -> RD_ADDR; any other byte ignored, stay IDLE, no FRAME_ERR.
REQ-020 WR_ADDR/RD_ADDR: on RX_D_VLD, upper nibble 0 -> latch low nibble into Address, go WR_DATA/RD_EXEC; upper nibble nonzero -> FRAME_ERR, IDLE.
REQ-021 WR_DATA: on RX_D_VLD latch byte into WrData, go WR_EXEC.
REQ-022 WR_EXEC: WrEn=1 for exactly one cycle with Address/WrData stable, then IDLE.
REQ-023 RD_EXEC: RdEn=1 for exactly one cycle, then RD_WAIT with timeout counter cleared.
REQ-024 RD_WAIT: on Rd_D_Vid latch RdData into TX_P_DATA, go TX_SEND; counter reaching RD_TIMEOUT without Rd_D_Vid -> FRAME_ERR, IDLE.
REQ-025 TX_SEND: when TX_BUSY=0 assert TX_D_VLD one cycle, then IDLE; while TX_BUSY=1 hold state, TX_D_VLD=0.
REQ-026 WrEn and RdEn SHALL never be high in the same cycle.
REQ-027 Rd_D_Vid outside RD_WAIT SHALL be ignored.
REQ-028 RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT, TX_SEND: byte dropped, FRAME_ERR pulses, state unaffected.
REQ-029 Address, WrData, TX_P_DATA hold last latched value until next latch.
REQ-030 Latency: WrEn asserted the cycle after the data byte's RX_D_VLD; RdEn the cycle after the address byte's RX_D_VLD; TX_D_VLD earliest the cycle after Rd_D_Vid.
REQ-031 Timeout counter width SHALL hold RD_TIMEOUT without wrap.

Reset
REQ-032 RST=1 at a clock edge: state IDLE; WrEn, RdEn, TX_D_VLD, FRAME_ERR =0; Address=0; WrData=0; TX_P_DATA=0; counter=0.
REQ-033 RST mid-frame aborts the frame with no strobe issued and no FRAME_ERR.

Verification
REQ-034 Bytes AA,03,5C -> single WrEn pulse, Address=3, WrData=5C, RdEn never high.
REQ-035 Bytes BB,01; Rd_D_Vid with RdData=7E one cycle after RdEn; TX_BUSY=0 -> one TX_D_VLD, TX_P_DATA=7E.
REQ-036 Read as above with TX_BUSY=1 for 10 cycles -> TX_D_VLD only after TX_BUSY falls, exactly once.
REQ-037 Bytes BB,02, no Rd_D_Vid -> FRAME_ERR after RD_TIMEOUT (15) cycles, IDLE, no TX_D_VLD.
REQ-038 Bytes AA,13 -> FRAME_ERR, no WrEn; then byte 55 ignored; then AA,00,FF -> write to 0.
REQ-039 Bytes AA,04 then RST=1 -> no WrEn, outputs at reset values; next frame AA,04,11 -> normal write.

Source files
------------

// File: rtl/reg_access_ctrl.sv
// Command-frame decoder: turns UART byte frames into register-file write/read
// strobes and forwards read data back to the UART transmitter.
module reg_access_ctrl #(
  parameter logic [7:0] WR_CMD     = 8'hAA,
  parameter logic [7:0] RD_CMD     = 8'hBB,
  parameter int         RD_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_P_DATA,
  input  logic       RX_D_VLD,
  output logic       WrEn,
  output logic       RdEn,
  output logic [3:0] Address,
  output logic [7:0] WrData,
  input  logic [7:0] RdData,
  input  logic       Rd_D_Vid,
  output logic [7:0] TX_P_DATA,
  output logic       TX_D_VLD,
  input  logic       TX_BUSY,
  output logic       FRAME_ERR
);

  localparam int CNT_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_EXEC,
    RD_ADDR,
    RD_EXEC,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t             state_reg, state_next;
  logic [3:0]         addr_reg, addr_next;
  logic [7:0]         wr_data_reg, wr_data_next;
  logic [7:0]         tx_data_reg, tx_data_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               frame_err_reg, frame_err_next;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      wr_data_reg   <= '0;
      tx_data_reg   <= '0;
      cnt_reg       <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      wr_data_reg   <= wr_data_next;
      tx_data_reg   <= tx_data_next;
      cnt_reg       <= cnt_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    wr_data_next   = wr_data_reg;
    tx_data_next   = tx_data_reg;
    cnt_next       = cnt_reg;
    frame_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD)      state_next = WR_ADDR;
          else if (RX_P_DATA == RD_CMD) state_next = RD_ADDR;
        end
      end

      WR_ADDR, RD_ADDR: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA[7:4] == 4'h0) begin
            addr_next  = RX_P_DATA[3:0];
            state_next = (state_reg == WR_ADDR) ? WR_DATA : RD_EXEC;
          end else begin
            frame_err_next = 1'b1;
            state_next     = IDLE;
          end
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_next = RX_P_DATA;
          state_next   = WR_EXEC;
        end
      end

      // Bytes arriving while a strobe or reply is in flight are dropped and flagged.
      WR_EXEC: begin
        frame_err_next = RX_D_VLD;
        state_next     = IDLE;
      end

      RD_EXEC: begin
        frame_err_next = RX_D_VLD;
        cnt_next       = '0;
        state_next     = RD_WAIT;
      end

      RD_WAIT: begin
        frame_err_next = RX_D_VLD;
        if (Rd_D_Vid) begin
          tx_data_next = RdData;
          state_next   = TX_SEND;
        end else begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_next == CNT_W'(RD_TIMEOUT)) begin
            frame_err_next = 1'b1;
            state_next     = IDLE;
          end
        end
      end

      TX_SEND: begin
        frame_err_next = RX_D_VLD;
        if (!TX_BUSY) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign WrEn      = (state_reg == WR_EXEC);
  assign RdEn      = (state_reg == RD_EXEC);
  assign TX_D_VLD  = (state_reg == TX_SEND) && !TX_BUSY;
  assign Address   = addr_reg;
  assign WrData    = wr_data_reg;
  assign TX_P_DATA = tx_data_reg;
  assign FRAME_ERR = frame_err_reg;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl: write/read frames, busy back-pressure,
// read timeout, malformed frames and mid-frame reset.
module tb_reg_access_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData;
  logic       Rd_D_Vid;
  logic [7:0] TX_P_DATA;
  logic       TX_D_VLD;
  logic       TX_BUSY;
  logic       FRAME_ERR;

  int checks = 0;
  int errors = 0;

  int wr_total = 0, rd_total = 0, tx_total = 0, both_total = 0;
  int w0, r0, t0;
  int n;

  reg_access_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .Rd_D_Vid(Rd_D_Vid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // Strobe counters sampled mid-cycle.
  always @(negedge CLK) begin
    if (WrEn)         wr_total++;
    if (RdEn)         rd_total++;
    if (TX_D_VLD)     tx_total++;
    if (WrEn && RdEn) both_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
    $display("rx byte %02h", b);
  endtask

  task automatic snap();
    w0 = wr_total;
    r0 = rd_total;
    t0 = tx_total;
  endtask

  initial begin
    RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
    RdData = 8'h00; Rd_D_Vid = 1'b0; TX_BUSY = 1'b0;
    tick(); tick(); tick();
    check("rst_wren", WrEn, 1'b0);
    check("rst_rden", RdEn, 1'b0);
    check("rst_txvld", TX_D_VLD, 1'b0);
    check("rst_ferr", FRAME_ERR, 1'b0);
    check("rst_addr", Address, 4'h0);
    check("rst_wrdata", WrData, 8'h00);
    check("rst_txdata", TX_P_DATA, 8'h00);
    RST = 1'b0;
    tick();

    // Plain write AA,03,5C
    snap();
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h5C);
    check("wr1_wren", WrEn, 1'b1);
    check("wr1_addr", Address, 4'h3);
    check("wr1_data", WrData, 8'h5C);
    tick();
    check("wr1_wren_off", WrEn, 1'b0);
    tick();
    check("wr1_count", wr_total - w0, 1);
    check("wr1_no_rd", rd_total - r0, 0);
    $display("write frame AA 03 5C done");

    // Read BB,01 with data one cycle after RdEn, transmitter idle
    snap();
    send_byte(8'hBB); send_byte(8'h01);
    check("rd1_rden", RdEn, 1'b1);
    check("rd1_addr", Address, 4'h1);
    tick();
    check("rd1_rden_off", RdEn, 1'b0);
    RdData = 8'h7E; Rd_D_Vid = 1'b1;
    tick();
    Rd_D_Vid = 1'b0;
    check("rd1_txvld", TX_D_VLD, 1'b1);
    check("rd1_txdata", TX_P_DATA, 8'h7E);
    tick();
    check("rd1_txvld_off", TX_D_VLD, 1'b0);
    tick();
    check("rd1_tx_count", tx_total - t0, 1);
    check("rd1_rd_count", rd_total - r0, 1);
    $display("read frame BB 01 -> 7E done");

    // Read with transmitter busy for 10 cycles
    snap();
    TX_BUSY = 1'b1;
    send_byte(8'hBB); send_byte(8'h05);
    tick();
    RdData = 8'h3C; Rd_D_Vid = 1'b1;
    tick();
    Rd_D_Vid = 1'b0;
    check("busy_txvld_held", TX_D_VLD, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("busy_no_tx", tx_total - t0, 0);
    TX_BUSY = 1'b0;
    #1;
    check("busy_txvld", TX_D_VLD, 1'b1);
    check("busy_txdata", TX_P_DATA, 8'h3C);
    tick();
    check("busy_txvld_off", TX_D_VLD, 1'b0);
    tick();
    check("busy_tx_count", tx_total - t0, 1);
    $display("busy read frame BB 05 -> 3C done");

    // Read timeout: BB,02 and no read-data valid
    snap();
    send_byte(8'hBB); send_byte(8'h02);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (FRAME_ERR) begin
        n = i;
        break;
      end
    end
    check("to_cycles", n, 16);
    tick();
    check("to_ferr_pulse", FRAME_ERR, 1'b0);
    check("to_no_tx", tx_total - t0, 0);
    // A late read-data valid in IDLE must not produce a reply
    RdData = 8'h99; Rd_D_Vid = 1'b1;
    tick();
    Rd_D_Vid = 1'b0;
    check("late_vid_txvld", TX_D_VLD, 1'b0);
    check("late_vid_txdata", TX_P_DATA, 8'h3C);
    $display("read timeout frame BB 02 done");

    // Bad address, ignored byte, then write to address 0
    snap();
    send_byte(8'hAA); send_byte(8'h13);
    check("badaddr_ferr", FRAME_ERR, 1'b1);
    tick();
    check("badaddr_ferr_off", FRAME_ERR, 1'b0);
    send_byte(8'h55);
    check("ignored_no_ferr", FRAME_ERR, 1'b0);
    check("badaddr_no_wr", wr_total - w0, 0);
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'hFF);
    check("wr0_wren", WrEn, 1'b1);
    check("wr0_addr", Address, 4'h0);
    check("wr0_data", WrData, 8'hFF);
    tick();
    check("wr0_count", wr_total - w0, 1);
    $display("bad frame AA 13, byte 55, write AA 00 FF done");

    // Reset in the middle of a write frame
    snap();
    send_byte(8'hAA); send_byte(8'h04);
    RST = 1'b1;
    tick();
    check("mrst_wren", WrEn, 1'b0);
    check("mrst_ferr", FRAME_ERR, 1'b0);
    check("mrst_addr", Address, 4'h0);
    check("mrst_wrdata", WrData, 8'h00);
    check("mrst_txdata", TX_P_DATA, 8'h00);
    RST = 1'b0;
    tick();
    check("mrst_no_wr", wr_total - w0, 0);
    send_byte(8'hAA); send_byte(8'h04); send_byte(8'h11);
    check("post_rst_wren", WrEn, 1'b1);
    check("post_rst_addr", Address, 4'h4);
    check("post_rst_data", WrData, 8'h11);
    tick();
    $display("mid-frame reset then write AA 04 11 done");

    // Byte arriving while a reply is held by a busy transmitter
    snap();
    TX_BUSY = 1'b1;
    send_byte(8'hBB); send_byte(8'h06);
    tick();
    RdData = 8'hA5; Rd_D_Vid = 1'b1;
    tick();
    Rd_D_Vid = 1'b0;
    send_byte(8'hAA);
    check("drop_ferr", FRAME_ERR, 1'b1);
    check("drop_txvld_held", TX_D_VLD, 1'b0);
    TX_BUSY = 1'b0;
    #1;
    check("drop_txvld", TX_D_VLD, 1'b1);
    check("drop_txdata", TX_P_DATA, 8'hA5);
    tick(); tick();
    check("drop_tx_count", tx_total - t0, 1);
    check("wr_rd_exclusive", both_total, 0);
    $display("byte dropped during TX_SEND done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
